// File: rtl/xbar_slave_arbiter_if.sv
// Request/response bundle between two crossbar masters, one slave-port arbiter and its slave.
// The "slave" modport is the arbiter's view; "master" is the view of whatever drives the masters and the slave.
interface xbar_slave_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_cmd;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_cmd;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic              s_req;
  logic              s_cmd;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;
  logic              s_ack;

  logic [1:0]        grant;

  modport slave (
    input  m0_req, m0_cmd, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_cmd, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output s_req, s_cmd, s_addr, s_wdata,
    input  s_rdata, s_ack,
    output grant
  );

  modport master (
    output m0_req, m0_cmd, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_cmd, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  s_req, s_cmd, s_addr, s_wdata,
    output s_rdata, s_ack,
    input  grant
  );
endinterface

// File: rtl/xbar_slave_arbiter.sv
// Per-slave arbiter of a 2x2 crossbar: round-robin between two masters, forwards the winner's
// request to the slave, holds it until the slave acks, then returns ack/rdata to the winner only.
module xbar_slave_arbiter #(
  parameter int SLAVE_ID = 0,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  xbar_slave_arbiter_if.slave bus
);

  localparam logic SEL_BIT = 1'(SLAVE_ID);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        grant_q, grant_d;
  logic              s_req_q, s_req_d;
  logic              s_cmd_q, s_cmd_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;

  logic m0_elig_s;
  logic m1_elig_s;
  logic pick_m1_s;

  assign m0_elig_s = bus.m0_req && (bus.m0_addr[ADDR_W-1] == SEL_BIT);
  assign m1_elig_s = bus.m1_req && (bus.m1_addr[ADDR_W-1] == SEL_BIT);
  // On a tie the master that did not win last time takes the slave.
  assign pick_m1_s = m1_elig_s && (!m0_elig_s || !last_grant_q);

  // Next-state and next-output logic for the IDLE -> BUSY -> ACK cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    s_req_d      = s_req_q;
    s_cmd_d      = s_cmd_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_elig_s || m1_elig_s) begin
          state_d      = ST_BUSY;
          s_req_d      = 1'b1;
          last_grant_d = pick_m1_s;
          grant_d      = pick_m1_s ? 2'b10 : 2'b01;
          s_cmd_d      = pick_m1_s ? bus.m1_cmd   : bus.m0_cmd;
          s_addr_d     = pick_m1_s ? bus.m1_addr  : bus.m0_addr;
          s_wdata_d    = pick_m1_s ? bus.m1_wdata : bus.m0_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.s_ack) begin
          state_d    = ST_ACK;
          s_req_d    = 1'b0;
          m0_ack_d   = grant_q[0];
          m1_ack_d   = grant_q[1];
          m0_rdata_d = (grant_q[0] && !s_cmd_q) ? bus.s_rdata : m0_rdata_q;
          m1_rdata_d = (grant_q[1] && !s_cmd_q) ? bus.s_rdata : m1_rdata_q;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        s_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; last_grant resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      s_req_q      <= 1'b0;
      s_cmd_q      <= 1'b0;
      s_addr_q     <= {ADDR_W{1'b0}};
      s_wdata_q    <= {DATA_W{1'b0}};
      m0_rdata_q   <= {DATA_W{1'b0}};
      m1_rdata_q   <= {DATA_W{1'b0}};
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      s_req_q      <= s_req_d;
      s_cmd_q      <= s_cmd_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
    end
  end

  assign bus.s_req    = s_req_q;
  assign bus.s_cmd    = s_cmd_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.grant    = grant_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Bench for two arbiter instances (SLAVE_ID 0 and 1) sharing the same two masters, as in the crossbar.
module tb_xbar_slave_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m_req_v   [2];
  logic        m_cmd_v   [2];
  logic [31:0] m_addr_v  [2];
  logic [31:0] m_wdata_v [2];
  logic        s_ack_v   [2];
  logic [31:0] s_rdata_v [2];

  logic        s_req_w   [2];
  logic        s_cmd_w   [2];
  logic [31:0] s_addr_w  [2];
  logic [31:0] s_wdata_w [2];
  logic [1:0]  grant_w   [2];
  logic [1:0]  ack_w     [2];
  logic [31:0] rdata_w   [2][2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: which master each slave port served last, and what each master last read from it.
  logic        exp_last  [2];
  logic [31:0] exp_rdata [2][2];

  xbar_slave_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  xbar_slave_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

  xbar_slave_arbiter #(.SLAVE_ID(0), .ADDR_W(32), .DATA_W(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  xbar_slave_arbiter #(.SLAVE_ID(1), .ADDR_W(32), .DATA_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.m0_req = m_req_v[0];   assign if1.m0_req = m_req_v[0];
  assign if0.m0_cmd = m_cmd_v[0];   assign if1.m0_cmd = m_cmd_v[0];
  assign if0.m0_addr = m_addr_v[0]; assign if1.m0_addr = m_addr_v[0];
  assign if0.m0_wdata = m_wdata_v[0]; assign if1.m0_wdata = m_wdata_v[0];
  assign if0.m1_req = m_req_v[1];   assign if1.m1_req = m_req_v[1];
  assign if0.m1_cmd = m_cmd_v[1];   assign if1.m1_cmd = m_cmd_v[1];
  assign if0.m1_addr = m_addr_v[1]; assign if1.m1_addr = m_addr_v[1];
  assign if0.m1_wdata = m_wdata_v[1]; assign if1.m1_wdata = m_wdata_v[1];
  assign if0.s_ack = s_ack_v[0];    assign if1.s_ack = s_ack_v[1];
  assign if0.s_rdata = s_rdata_v[0]; assign if1.s_rdata = s_rdata_v[1];

  assign s_req_w[0] = if0.s_req;     assign s_req_w[1] = if1.s_req;
  assign s_cmd_w[0] = if0.s_cmd;     assign s_cmd_w[1] = if1.s_cmd;
  assign s_addr_w[0] = if0.s_addr;   assign s_addr_w[1] = if1.s_addr;
  assign s_wdata_w[0] = if0.s_wdata; assign s_wdata_w[1] = if1.s_wdata;
  assign grant_w[0] = if0.grant;     assign grant_w[1] = if1.grant;
  assign ack_w[0] = {if0.m1_ack, if0.m0_ack};
  assign ack_w[1] = {if1.m1_ack, if1.m0_ack};
  assign rdata_w[0][0] = if0.m0_rdata; assign rdata_w[0][1] = if0.m1_rdata;
  assign rdata_w[1][0] = if1.m0_rdata; assign rdata_w[1][1] = if1.m1_rdata;

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      m_req_v[i] = 1'b0; m_cmd_v[i] = 1'b0; m_addr_v[i] = 32'h0; m_wdata_v[i] = 32'h0;
      s_ack_v[i] = 1'b0; s_rdata_v[i] = 32'h0;
      exp_last[i] = 1'b1; exp_rdata[i][0] = 32'h0; exp_rdata[i][1] = 32'h0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({s_req_w[i], s_cmd_w[i], grant_w[i], ack_w[i]} !== 6'b0) begin
        n_fail++; $display("FAIL reset_ctrl inst%0d: got %b required 000000", i, {s_req_w[i], s_cmd_w[i], grant_w[i], ack_w[i]});
      end
      n_tests++;
      if ({s_addr_w[i], s_wdata_w[i], rdata_w[i][0], rdata_w[i][1]} !== 128'h0) begin
        n_fail++; $display("FAIL reset_data inst%0d: got %h required 0", i, {s_addr_w[i], s_wdata_w[i], rdata_w[i][0], rdata_w[i][1]});
      end
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m_req_v[0] = 1'b1; m_cmd_v[0] = 1'b0; m_addr_v[0] = 32'h0000_0010; m_wdata_v[0] = 32'h5555_AAAA;
    @(negedge clk);
    n_tests++;
    if ({s_req_w[0], grant_w[0], s_addr_w[0], s_req_w[1]} !== {1'b1, 2'b01, 32'h10, 1'b0}) begin
      n_fail++; $display("FAIL read_grant: got req=%b grant=%b addr=%h other_req=%b required 1 01 00000010 0", s_req_w[0], grant_w[0], s_addr_w[0], s_req_w[1]);
    end
    @(negedge clk);
    n_tests++;
    if ({s_req_w[0], s_addr_w[0]} !== {1'b1, 32'h10}) begin
      n_fail++; $display("FAIL read_hold: got req=%b addr=%h required 1 00000010", s_req_w[0], s_addr_w[0]);
    end
    s_ack_v[0] = 1'b1; s_rdata_v[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    exp_rdata[0][0] = 32'hDEAD_BEEF; exp_last[0] = 1'b0;
    n_tests++;
    if ({ack_w[0], ack_w[1], s_req_w[0], rdata_w[0][0]} !== {2'b01, 2'b00, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL read_ack: got ack=%b other=%b req=%b rdata=%h required 01 00 0 deadbeef", ack_w[0], ack_w[1], s_req_w[0], rdata_w[0][0]);
    end
    s_ack_v[0] = 1'b0; m_req_v[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ack_w[0], grant_w[0], rdata_w[0][0]} !== {2'b00, 2'b00, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL read_done: got ack=%b grant=%b rdata=%h required 00 00 deadbeef", ack_w[0], grant_w[0], rdata_w[0][0]);
    end
  endtask

  task automatic test_write_filter();
    @(negedge clk);
    m_req_v[1] = 1'b1; m_cmd_v[1] = 1'b1; m_addr_v[1] = 32'h8000_0004; m_wdata_v[1] = 32'h1234_5678;
    s_rdata_v[1] = 32'hFFFF_FFFF;
    @(negedge clk);
    n_tests++;
    if ({s_req_w[1], s_cmd_w[1], grant_w[1], s_addr_w[1], s_wdata_w[1]} !== {1'b1, 1'b1, 2'b10, 32'h8000_0004, 32'h1234_5678}) begin
      n_fail++; $display("FAIL write_fwd: got req=%b cmd=%b grant=%b addr=%h wdata=%h required 1 1 10 80000004 12345678", s_req_w[1], s_cmd_w[1], grant_w[1], s_addr_w[1], s_wdata_w[1]);
    end
    n_tests++;
    if (s_req_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL write_filter_grant: got s_req=%b on SLAVE_ID=0 required 0", s_req_w[0]);
    end
    s_ack_v[1] = 1'b1;
    @(negedge clk);
    exp_last[1] = 1'b1;
    n_tests++;
    if ({ack_w[1], rdata_w[1][1], s_req_w[0], ack_w[0]} !== {2'b10, exp_rdata[1][1], 1'b0, 2'b00}) begin
      n_fail++; $display("FAIL write_ack: got ack=%b rdata=%h other_req=%b other_ack=%b required 10 %h 0 00", ack_w[1], rdata_w[1][1], s_req_w[0], ack_w[0], exp_rdata[1][1]);
    end
    s_ack_v[1] = 1'b0; m_req_v[1] = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ack_w[1], grant_w[1], s_req_w[0]} !== 5'b0) begin
      n_fail++; $display("FAIL write_done: got ack=%b grant=%b other_req=%b required 00 00 0", ack_w[1], grant_w[1], s_req_w[0]);
    end
  endtask

  task automatic test_contention();
    logic [31:0] d;
    int w;
    do_reset();
    @(negedge clk);
    m_req_v[0] = 1'b1; m_cmd_v[0] = 1'b0; m_addr_v[0] = 32'h0000_0100;
    m_req_v[1] = 1'b1; m_cmd_v[1] = 1'b0; m_addr_v[1] = 32'h0000_0200;
    for (int g = 0; g < 4; g++) begin
      w = g % 2;
      @(negedge clk);
      n_tests++;
      if ({grant_w[0], s_addr_w[0]} !== {((w == 1) ? 2'b10 : 2'b01), m_addr_v[w]}) begin
        n_fail++; $display("FAIL contend_grant round%0d: got grant=%b addr=%h required master %0d", g, grant_w[0], s_addr_w[0], w);
      end
      s_ack_v[0] = 1'b1; s_rdata_v[0] = $urandom; d = s_rdata_v[0];
      @(negedge clk);
      exp_last[0] = 1'(w); exp_rdata[0][w] = d;
      n_tests++;
      if ({ack_w[0], rdata_w[0][w]} !== {((w == 1) ? 2'b10 : 2'b01), d}) begin
        n_fail++; $display("FAIL contend_ack round%0d: got ack=%b rdata=%h required master %0d data %h", g, ack_w[0], rdata_w[0][w], w, d);
      end
      s_ack_v[0] = 1'b0;
      if (g == 3) begin
        m_req_v[0] = 1'b0; m_req_v[1] = 1'b0;
      end
      @(negedge clk);
      n_tests++;
      if ({grant_w[0], ack_w[0], s_req_w[0]} !== 5'b0) begin
        n_fail++; $display("FAIL contend_idle round%0d: got grant=%b ack=%b req=%b required 00 00 0", g, grant_w[0], ack_w[0], s_req_w[0]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    @(negedge clk);
    m_req_v[0] = 1'b1; m_cmd_v[0] = 1'b0; m_addr_v[0] = 32'h0000_0040;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_tests++;
      if ({s_req_w[0], grant_w[0], s_addr_w[0]} !== {1'b1, 2'b01, 32'h40}) begin
        n_fail++; $display("FAIL stall_hold cycle%0d: got req=%b grant=%b addr=%h required 1 01 00000040", c, s_req_w[0], grant_w[0], s_addr_w[0]);
      end
      if (c == 3) begin
        m_req_v[0] = 1'b0; m_addr_v[0] = 32'h0000_0999;
      end
    end
    s_ack_v[0] = 1'b1; s_rdata_v[0] = $urandom; d = s_rdata_v[0];
    @(negedge clk);
    exp_last[0] = 1'b0; exp_rdata[0][0] = d;
    n_tests++;
    if ({ack_w[0], rdata_w[0][0]} !== {2'b01, d}) begin
      n_fail++; $display("FAIL stall_ack: got ack=%b rdata=%h required 01 %h", ack_w[0], rdata_w[0][0], d);
    end
    s_ack_v[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ack_w[0], grant_w[0]} !== 4'b0) begin
      n_fail++; $display("FAIL stall_done: got ack=%b grant=%b required 00 00", ack_w[0], grant_w[0]);
    end
  endtask

  task automatic test_spurious();
    logic [31:0] d;
    @(negedge clk);
    s_ack_v[0] = 1'b1; s_ack_v[1] = 1'b1; s_rdata_v[0] = $urandom; s_rdata_v[1] = $urandom;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if ({ack_w[i], grant_w[i], s_req_w[i], rdata_w[i][0], rdata_w[i][1]} !== {5'b0, exp_rdata[i][0], exp_rdata[i][1]}) begin
          n_fail++; $display("FAIL spurious inst%0d: got ack=%b grant=%b req=%b rdata=%h/%h", i, ack_w[i], grant_w[i], s_req_w[i], rdata_w[i][0], rdata_w[i][1]);
        end
      end
    end
    s_ack_v[0] = 1'b0; s_ack_v[1] = 1'b0;
    m_req_v[1] = 1'b1; m_cmd_v[1] = 1'b0; m_addr_v[1] = 32'h0000_0300;
    @(negedge clk);
    n_tests++;
    if ({grant_w[0], s_req_w[0]} !== 3'b101) begin
      n_fail++; $display("FAIL spurious_idle: got grant=%b req=%b required 10 1", grant_w[0], s_req_w[0]);
    end
    s_ack_v[0] = 1'b1; s_rdata_v[0] = $urandom; d = s_rdata_v[0];
    @(negedge clk);
    exp_last[0] = 1'b1; exp_rdata[0][1] = d;
    n_tests++;
    if ({ack_w[0], rdata_w[0][1]} !== {2'b10, d}) begin
      n_fail++; $display("FAIL spurious_follow_ack: got ack=%b rdata=%h required 10 %h", ack_w[0], rdata_w[0][1], d);
    end
    s_ack_v[0] = 1'b0; m_req_v[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_req_v[0] = 1'b1; m_cmd_v[0] = 1'b0; m_addr_v[0] = 32'h0000_0080;
    @(negedge clk);
    n_tests++;
    if (s_req_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_busy: got s_req=%b required 1", s_req_w[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({s_req_w[i], grant_w[i], ack_w[i], rdata_w[i][0], rdata_w[i][1]} !== 69'h0) begin
        n_fail++; $display("FAIL rstmid_async inst%0d: got req=%b grant=%b ack=%b rdata=%h/%h required all 0", i, s_req_w[i], grant_w[i], ack_w[i], rdata_w[i][0], rdata_w[i][1]);
      end
    end
    m_req_v[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_last[i] = 1'b1; exp_rdata[i][0] = 32'h0; exp_rdata[i][1] = 32'h0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_req_v[0] = 1'b1; m_addr_v[0] = 32'h0000_0008;
    m_req_v[1] = 1'b1; m_cmd_v[1] = 1'b0; m_addr_v[1] = 32'h0000_000C;
    @(negedge clk);
    n_tests++;
    if ({grant_w[0], ack_w[0]} !== 4'b0100) begin
      n_fail++; $display("FAIL rstmid_first_grant: got grant=%b ack=%b required 01 00", grant_w[0], ack_w[0]);
    end
  endtask

  // Random traffic from both masters to both slave ports, checked transaction by transaction.
  task automatic test_random();
    int          ord  [2][2];
    int          nord [2];
    int          pos  [2];
    int          cnt  [2];
    int          lat  [2];
    logic [31:0] ack_dat [2];
    logic        tgt  [2];
    logic        e0, e1;
    logic [1:0]  exp_g;
    int          w;
    bit          done;
    do_reset();
    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        tgt[m]       = 1'($urandom_range(0, 1));
        m_req_v[m]   = ($urandom_range(0, 3) != 0);
        m_cmd_v[m]   = 1'($urandom_range(0, 1));
        m_addr_v[m]  = $urandom;
        m_addr_v[m][31] = tgt[m];
        m_wdata_v[m] = $urandom;
      end
      for (int i = 0; i < 2; i++) begin
        e0 = m_req_v[0] && (tgt[0] == 1'(i));
        e1 = m_req_v[1] && (tgt[1] == 1'(i));
        nord[i] = 0; pos[i] = 0; cnt[i] = 0; lat[i] = 1;
        if (e0 && e1) begin
          ord[i][0] = exp_last[i] ? 0 : 1;
          ord[i][1] = 1 - ord[i][0];
          nord[i] = 2;
        end else if (e0) begin
          ord[i][0] = 0; nord[i] = 1;
        end else if (e1) begin
          ord[i][0] = 1; nord[i] = 1;
        end
        if (nord[i] > 0) exp_last[i] = 1'(ord[i][nord[i]-1]);
      end
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          if (s_req_w[i]) begin
            if (cnt[i] == 0) begin
              n_tests++;
              if (pos[i] >= nord[i]) begin
                n_fail++; $display("FAIL rand_grant r%0d inst%0d: got unexpected grant %b required none", r, i, grant_w[i]);
              end else begin
                w = ord[i][pos[i]];
                exp_g = (w == 1) ? 2'b10 : 2'b01;
                if ({grant_w[i], s_cmd_w[i], s_addr_w[i], s_wdata_w[i]} !== {exp_g, m_cmd_v[w], m_addr_v[w], m_wdata_v[w]}) begin
                  n_fail++; $display("FAIL rand_fwd r%0d inst%0d: got grant=%b cmd=%b addr=%h wdata=%h required master %0d", r, i, grant_w[i], s_cmd_w[i], s_addr_w[i], s_wdata_w[i], w);
                end
              end
              lat[i] = int'($urandom_range(1, 4));
            end
            cnt[i]++;
            if (cnt[i] == lat[i]) begin
              s_ack_v[i] = 1'b1; s_rdata_v[i] = $urandom; ack_dat[i] = s_rdata_v[i];
            end else begin
              s_ack_v[i] = 1'b0;
            end
          end else begin
            cnt[i] = 0; s_ack_v[i] = 1'b0;
            if (ack_w[i] == 2'b00) begin
              n_tests++;
              if (grant_w[i] !== 2'b00) begin
                n_fail++; $display("FAIL rand_idle r%0d inst%0d: got grant=%b required 00", r, i, grant_w[i]);
              end
            end
          end
          for (int m = 0; m < 2; m++) begin
            if (ack_w[i][m]) begin
              n_tests++;
              if (pos[i] >= nord[i] || ord[i][pos[i]] != m) begin
                n_fail++; $display("FAIL rand_ack r%0d inst%0d: got ack for master %0d required none or other", r, i, m);
              end else begin
                if (!m_cmd_v[m]) exp_rdata[i][m] = ack_dat[i];
                pos[i]++;
              end
              m_req_v[m] = 1'b0;
            end
          end
          for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (rdata_w[i][m] !== exp_rdata[i][m]) begin
              n_fail++; $display("FAIL rand_rdata r%0d inst%0d m%0d: got %h required %h", r, i, m, rdata_w[i][m], exp_rdata[i][m]);
            end
          end
        end
        done = (pos[0] == nord[0]) && (pos[1] == nord[1]);
      end
      n_tests++;
      if (!done) begin
        n_fail++; $display("FAIL rand_timeout r%0d: got %0d/%0d and %0d/%0d acks required all", r, pos[0], nord[0], pos[1], nord[1]);
        m_req_v[0] = 1'b0; m_req_v[1] = 1'b0;
        do_reset();
      end
      @(negedge clk);
      n_tests++;
      if ({grant_w[0], grant_w[1], ack_w[0], ack_w[1]} !== 8'b0) begin
        n_fail++; $display("FAIL rand_end r%0d: got grant=%b/%b ack=%b/%b required 0", r, grant_w[0], grant_w[1], ack_w[0], ack_w[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_filter();
    test_contention();
    test_stall();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
